// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state codes and baud divider helper
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // Clocks per oversample tick; truncating division, so the line rate runs slightly fast.
  function automatic int calc_tick_div(input int clk_freq, input int baud_rate,
                                       input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, phase restarted by clr
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = !clr && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing error flag
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("uart_rx: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE (TICK_DIV < 1)");
  end
  if ((OVERSAMPLE < 8) || ((OVERSAMPLE & (OVERSAMPLE - 1)) != 0)) begin : g_bad_os
    $error("uart_rx: OVERSAMPLE must be a power of two >= 8");
  end

  logic                 r_sync1;
  logic                 r_sync2;
  logic [2:0]           r_state;
  logic [SW-1:0]        r_sample_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 w_rx_s;
  logic                 w_tick;
  logic                 w_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;
  // Tick phase restarts at the detected start edge so samples land mid-bit.
  assign w_clr  = (r_state == ST_IDLE);

  uart_baud_tick #(
    .DIV (TICK_DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sample_cnt <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sample_cnt <= '0;
          r_bit_idx    <= '0;
          if (!w_rx_s) r_state <= ST_START;
        end
        ST_START: if (w_tick) begin
          if (r_sample_cnt == HALF_LAST) begin
            r_sample_cnt <= '0;
            r_state      <= w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_sample_cnt <= r_sample_cnt + SW'(1);
          end
        end
        ST_DATA: if (w_tick) begin
          if (r_sample_cnt == FULL_LAST) begin
            r_sample_cnt <= '0;
            r_shift      <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_idx    <= r_bit_idx + 3'd1;
            if (r_bit_idx == BIT_LAST) r_state <= ST_STOP;
          end else begin
            r_sample_cnt <= r_sample_cnt + SW'(1);
          end
        end
        ST_STOP: if (w_tick) begin
          if (r_sample_cnt == FULL_LAST) begin
            r_sample_cnt <= '0;
            if (w_rx_s) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_BREAK;
            end
          end else begin
            r_sample_cnt <= r_sample_cnt + SW'(1);
          end
        end
        // Hold off until the line recovers so a long low level is not seen as a new start.
        ST_BREAK: if (w_rx_s) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign rx_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;

  localparam int CLK_FREQ   = 1600000;
  localparam int BAUD_RATE  = 10000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = CLK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_both   = 0;
  int n_long   = 0;
  int last_valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_ferr  = 1'b0;
  logic [7:0] valid_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_valid++;
      valid_q.push_back(rx_data);
      last_valid_cyc = cyc;
    end
    if (frame_err === 1'b1) n_ferr++;
    if (rx_valid === 1'b1 && frame_err === 1'b1) n_both++;
    if ((rx_valid === 1'b1 && prev_valid) || (frame_err === 1'b1 && prev_ferr)) n_long++;
    prev_valid = (rx_valid === 1'b1);
    prev_ferr  = (frame_err === 1'b1);
  end

  // Line driver: start bit, LSB-first data, stop level held stop_len clocks, then idle high.
  task automatic drive_frame(input logic [7:0] b, input int bclk, input logic stop_v,
                             input int stop_len);
    rx = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bclk) @(negedge clk);
    end
    rx = stop_v;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy got %b want 0", rx_busy); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single();
    int v0, f0, t0;
    logic busy_mid;
    v0 = n_valid; f0 = n_ferr; valid_q.delete();
    t0 = cyc;
    busy_mid = 1'b0;
    fork
      drive_frame(8'hA5, BIT_CLKS, 1'b1, BIT_CLKS);
      begin repeat (5) @(negedge clk); busy_mid = rx_busy; end
    join
    repeat (30) @(negedge clk);
    exp_data = 8'hA5;
    n_checks++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL single_valid_count got %0d want 1", n_valid - v0); end
    n_checks++; if (valid_q.size() != 1 || valid_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", rx_data); end
    n_checks++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL single_ferr got %0d want 0", n_ferr - f0); end
    n_checks++; if (last_valid_cyc - t0 < 1521 || last_valid_cyc - t0 > 1525) begin n_fail++; $display("FAIL single_latency got %0d want 1523+-2", last_valid_cyc - t0); end
    n_checks++; if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL single_busy_mid got %b want 1", busy_mid); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b want 0", rx_busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int f0;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
    f0 = n_ferr; valid_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      drive_frame(bytes[i], BIT_CLKS, 1'b1, BIT_CLKS);
      exp_q.push_back(bytes[i]);
    end
    repeat (30) @(negedge clk);
    exp_data = 8'h55;
    n_checks++; if (valid_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", valid_q.size(), exp_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (i >= valid_q.size() || valid_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d got %h want %h", i, (i < valid_q.size()) ? valid_q[i] : 8'hxx, exp_q[i]); end
    end
    n_checks++; if (n_ferr != f0) begin n_fail++; $display("FAIL b2b_ferr got %0d want 0", n_ferr - f0); end
  endtask

  task automatic test_random();
    int f0, bclk, gap;
    logic [7:0] b;
    f0 = n_ferr; valid_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      bclk = BIT_CLKS - 3 + int'($urandom_range(0, 6));
      gap = int'($urandom_range(0, 40));
      drive_frame(b, bclk, 1'b1, bclk + gap);
      exp_q.push_back(b);
      exp_data = b;
    end
    repeat (30) @(negedge clk);
    n_checks++; if (valid_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", valid_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++; if (i >= valid_q.size() || valid_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d got %h want %h", i, (i < valid_q.size()) ? valid_q[i] : 8'hxx, exp_q[i]); end
    end
    n_checks++; if (n_ferr != f0) begin n_fail++; $display("FAIL rand_ferr got %0d want 0", n_ferr - f0); end
  endtask

  task automatic test_framing();
    int v0, f0;
    logic busy_low;
    v0 = n_valid; f0 = n_ferr; valid_q.delete();
    drive_frame(8'h3C, BIT_CLKS, 1'b0, 2 * BIT_CLKS - 1);
    rx = 1'b0;
    @(negedge clk);
    busy_low = rx_busy;
    rx = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL ferr_count got %0d want 1", n_ferr - f0); end
    n_checks++; if (n_valid != v0) begin n_fail++; $display("FAIL ferr_valid got %0d want 0", n_valid - v0); end
    n_checks++; if (rx_data !== exp_data) begin n_fail++; $display("FAIL ferr_hold got %h want %h", rx_data, exp_data); end
    n_checks++; if (busy_low !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_break got %b want 1", busy_low); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release got %b want 0", rx_busy); end
    drive_frame(8'h81, BIT_CLKS, 1'b1, BIT_CLKS);
    repeat (20) @(negedge clk);
    exp_data = 8'h81;
    n_checks++; if (valid_q.size() != 1 || valid_q[0] !== 8'h81) begin n_fail++; $display("FAIL ferr_next got %h want 81", rx_data); end
  endtask

  task automatic test_glitch();
    int v0, f0, g0, drop;
    v0 = n_valid; f0 = n_ferr;
    g0 = cyc; drop = -1;
    rx = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i == 49) rx = 1'b1;
      if (i >= 10 && drop < 0 && rx_busy === 1'b0) drop = cyc - g0;
    end
    n_checks++; if (drop < 0 || drop > 85) begin n_fail++; $display("FAIL glitch_busy_drop got %0d want <=85", drop); end
    n_checks++; if (n_valid != v0 || n_ferr != f0) begin n_fail++; $display("FAIL glitch_pulses got v%0d e%0d want 0", n_valid - v0, n_ferr - f0); end
  endtask

  task automatic test_baud_skew();
    int f0;
    f0 = n_ferr; valid_q.delete();
    drive_frame(8'hC3, BIT_CLKS * 97 / 100, 1'b1, BIT_CLKS);
    repeat (20) @(negedge clk);
    drive_frame(8'hC3, BIT_CLKS * 103 / 100, 1'b1, BIT_CLKS);
    repeat (20) @(negedge clk);
    exp_data = 8'hC3;
    n_checks++; if (valid_q.size() != 2) begin n_fail++; $display("FAIL skew_count got %0d want 2", valid_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (i >= valid_q.size() || valid_q[i] !== 8'hC3) begin n_fail++; $display("FAIL skew_byte%0d got %h want c3", i, (i < valid_q.size()) ? valid_q[i] : 8'hxx); end
    end
    n_checks++; if (n_ferr != f0) begin n_fail++; $display("FAIL skew_ferr got %0d want 0", n_ferr - f0); end
  endtask

  task automatic test_reset_mid();
    int v0, f0;
    logic [7:0] b;
    b = 8'h12;
    v0 = n_valid; f0 = n_ferr; valid_q.delete();
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    exp_data = 8'h00;
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", rx_busy); end
    n_checks++; if (rx_data !== exp_data) begin n_fail++; $display("FAIL rstmid_data got %h want 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulses got v%b e%b want 00", rx_valid, frame_err); end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (n_valid != v0 || n_ferr != f0) begin n_fail++; $display("FAIL rstmid_no_pulse got v%0d e%0d want 0", n_valid - v0, n_ferr - f0); end
    drive_frame(8'h34, BIT_CLKS, 1'b1, BIT_CLKS);
    repeat (20) @(negedge clk);
    exp_data = 8'h34;
    n_checks++; if (valid_q.size() != 1 || valid_q[0] !== 8'h34) begin n_fail++; $display("FAIL rstmid_next got %h want 34", rx_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_framing();
    test_glitch();
    test_baud_skew();
    test_reset_mid();
    n_checks++; if (n_both != 0) begin n_fail++; $display("FAIL exclusive_pulses got %0d want 0", n_both); end
    n_checks++; if (n_long != 0) begin n_fail++; $display("FAIL pulse_width got %0d want 0", n_long); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; consumes the serial line driven by the team's UART transmitter (uart_tx) and delivers parallel bytes to the host logic.
- Synchronises the asynchronous rx input, detects the start bit, and samples at mid-bit using an oversampled baud tick.
- Flags framing errors.
- Single-byte holding register, no FIFO; the downstream consumer must take each byte on the rx_valid pulse.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate in bits/s
- OVERSAMPLE, 16, ticks per bit; power of two, >= 8
- Derived localparam TICK_DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer division (325 at defaults). Elaboration error if TICK_DIV < 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx  in  1  serial line, asynchronous, idles high
- rx_data  out  8  last correctly framed byte; holds until the next good frame
- rx_valid  out  1  one-clk pulse: rx_data updated this cycle
- frame_err  out  1  one-clk pulse: stop bit sampled low
- rx_busy  out  1  high while a frame is in progress (any state except IDLE)

Behaviour:
- Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, rx_busy=0. State=IDLE. Both synchroniser flops=1. All counters=0. Reset mid-frame aborts the frame silently; no valid or error pulse.
- Synchroniser: 2-FF chain on rx, giving rx_s. All decisions use rx_s only (2-clk input latency).
- Tick generator: counter 0..TICK_DIV-1; tick pulses when the counter wraps. The counter is held at 0 in IDLE and starts on start detection, so bit phase is aligned to the detected edge.
- Sample counter (log2 OVERSAMPLE bits) counts ticks within a bit. Bit index is 3 bits.
- IDLE: rx_s==0 -> START; clear tick and sample counters.
- START: on tick number OVERSAMPLE/2 (mid start bit), sample rx_s.
  - rx_s==0 -> DATA, sample count cleared.
  - rx_s==1 -> glitch; return to IDLE with no pulse.
- DATA: every OVERSAMPLE ticks, sample rx_s. The sample shifts into the MSB of an 8-bit shift register (shift right; LSB is received first).
  - After bit_index 7 -> STOP.
  - bit_index wraps to 0.
- STOP: after OVERSAMPLE ticks, sample rx_s.
  - 1: rx_data<=shift register and rx_valid=1 on the next clk edge -> IDLE.
  - 0: frame_err=1 for one clk and rx_data is unchanged -> BREAK.
- BREAK: wait for rx_s==1 -> IDLE. Covers a line held low / break condition and prevents a false restart.
- rx_valid and frame_err are mutually exclusive and never high for more than one clk.
- Overrun: not detected. A new byte overwrites rx_data; the consumer is responsible.
- Back-to-back frames: a start edge arriving immediately after the stop sample is accepted. IDLE is re-entered the same clk, and detection occurs on the next clk.
- Frame latency: from the rx falling edge to rx_valid ≈ 2 + TICK_DIV*(OVERSAMPLE/2 + 9*OVERSAMPLE) + 1 clks. At the test parameters this is 1523 ± 1 clks.
- Sampling point tolerance: ±OVERSAMPLE/2 ticks of accumulated baud error over the frame.

Decomposition:
- Package uart_pkg:
  - rx state enumeration: IDLE, START, DATA, STOP, BREAK
  - DATA_BITS=8
  - shared helper for TICK_DIV computation
  - the package is reusable by uart_tx
- Sub-module uart_baud_tick: parameter DIV, input clr, output tick. Instantiated once here; reusable by an oversampled transmitter.

Test Plan (CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16 -> TICK_DIV=10, 160 clk/bit):
- Drive a BFM 8N1 frame of 8'hA5 -> exactly one rx_valid with rx_data=8'hA5, frame_err never high. rx_busy high from ~3 clks after the start edge until rx_valid.
- Connect uart_tx (same clk, BAUD_RATE) -> rx. Send 8'h00, 8'hFF, 8'h55 back-to-back -> three rx_valid pulses with the matching bytes in order, no frame_err.
- Drive 8'h3C with the stop bit held low, then the line high after 2 bit times -> one frame_err pulse, no rx_valid, rx_data retains its previous value. rx_busy stays high until the line returns high, then a following frame 8'h81 is received correctly.
- Drive a 50-clk low glitch on the idle line -> no rx_valid or frame_err; rx_busy drops within 85 clks of the glitch start.
- Send 8'hC3 at baud +3% and then -3% -> both frames received correctly.
- Assert rst mid-DATA of a frame 8'h12 -> all outputs return to reset values immediately with no pulses. A full frame 8'h34 sent after rst release is received correctly.
